// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Power-up and lock controller for a single PLL. The controller raises the
// PLL enable and waits a bounded time for a lock that stays stable. Only
// after that does it open the downstream clock gate. A timeout or a loss of
// lock starts a bounded number of relock attempts. When the attempts run
// out, the controller parks in a sticky FAULT state until START is dropped.
//
// Ports:
//   CLK          always-on reference clock; every register uses its rising edge
//   RESET        asynchronous, active-high reset
//   START        level request: 1 = bring the PLL up and keep it up, 0 = shut down
//   LOCK         PLL lock indication, asynchronous to CLK
//   PLL_EN       PLL enable
//   CLK_GATE_EN  downstream clock-gate enable, high only in RUN
//   READY        high only in RUN
//   FAULT        high only in FAULT
//   LOCK_LOST    one-cycle pulse when the synchronized lock falls in RUN
//   RETRY_COUNT  attempts used since the last IDLE or RUN entry
//   STATE        IDLE=0, WAIT_LOCK=1, SETTLE=2, RUN=3, OFF=4, FAULT=5
//
// Every output is registered and decoded from the next state. As a result,
// all outputs change on the same edge as STATE.

module pll_lock_sequencer #(
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 3,
    parameter int OFF_CYCLES    = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       LOCK,
    output logic       PLL_EN,
    output logic       CLK_GATE_EN,
    output logic       READY,
    output logic       FAULT,
    output logic       LOCK_LOST,
    output logic [3:0] RETRY_COUNT,
    output logic [2:0] STATE
);

    localparam int TW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int OW = (OFF_CYCLES    > 1) ? $clog2(OFF_CYCLES)    : 1;

    localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [OW-1:0] OFF_LAST    = OW'(OFF_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_OFF       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [SW-1:0]   settle_reg, settle_next;
    logic [OW-1:0]   off_reg, off_next;
    logic [3:0]      retry_reg, retry_next;
    logic            lock_lost_next;
    logic            lock_meta_reg, lock_s_reg;
    logic            in_attempt, stay_attempt;

    // Next-state logic. Checks are ordered by priority: START low first,
    // then a lock drop, then timeout, then settle completion.
    always_comb begin
        state_next     = state_reg;
        retry_next     = retry_reg;
        settle_next    = '0;
        off_next       = '0;
        lock_lost_next = 1'b0;

        if (!START) begin
            state_next = ST_IDLE;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // If lock arrives in the same cycle as the timeout, lock wins.
                    if (lock_s_reg) begin
                        state_next = ST_SETTLE;
                    end else if (timer_reg == TIMER_LAST) begin
                        if (retry_reg == RETRY_MAX) begin
                            state_next = ST_FAULT;
                        end else begin
                            state_next = ST_OFF;
                            retry_next = retry_reg + 4'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s_reg) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (timer_reg == TIMER_LAST) begin
                        if (retry_reg == RETRY_MAX) begin
                            state_next = ST_FAULT;
                        end else begin
                            state_next = ST_OFF;
                            retry_next = retry_reg + 4'd1;
                        end
                    end else if (settle_reg == SETTLE_LAST) begin
                        state_next = ST_RUN;
                        retry_next = '0;
                    end else begin
                        settle_next = settle_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_reg) begin
                        lock_lost_next = 1'b1;
                        if (retry_reg == RETRY_MAX) begin
                            state_next = ST_FAULT;
                        end else begin
                            state_next = ST_OFF;
                            retry_next = retry_reg + 4'd1;
                        end
                    end
                end
                ST_OFF: begin
                    if (off_reg == OFF_LAST) begin
                        state_next = ST_WAIT_LOCK;
                    end else begin
                        off_next = off_reg + 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_IDLE;
                    retry_next = '0;
                end
            endcase
        end
    end

    // The lock timer covers the whole attempt, across WAIT_LOCK and SETTLE,
    // and also across a SETTLE abort back to WAIT_LOCK. Any other entry into
    // WAIT_LOCK starts it again from zero. The timer saturates at its last
    // value instead of wrapping. This matters when a lock drop outranks a
    // timeout in SETTLE: the timeout is then taken on the next cycle.
    assign in_attempt   = (state_reg == ST_WAIT_LOCK) || (state_reg == ST_SETTLE);
    assign stay_attempt = (state_next == ST_WAIT_LOCK) || (state_next == ST_SETTLE);

    always_comb begin
        timer_next = '0;
        if (in_attempt && stay_attempt) begin
            timer_next = (timer_reg == TIMER_LAST) ? timer_reg : timer_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            settle_reg    <= '0;
            off_reg       <= '0;
            retry_reg     <= '0;
            PLL_EN        <= 1'b0;
            CLK_GATE_EN   <= 1'b0;
            READY         <= 1'b0;
            FAULT         <= 1'b0;
            LOCK_LOST     <= 1'b0;
        end else begin
            lock_meta_reg <= LOCK;
            lock_s_reg    <= lock_meta_reg;
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            settle_reg    <= settle_next;
            off_reg       <= off_next;
            retry_reg     <= retry_next;
            PLL_EN        <= (state_next == ST_WAIT_LOCK) || (state_next == ST_SETTLE) ||
                             (state_next == ST_RUN);
            CLK_GATE_EN   <= (state_next == ST_RUN);
            READY         <= (state_next == ST_RUN);
            FAULT         <= (state_next == ST_FAULT);
            LOCK_LOST     <= lock_lost_next;
        end
    end

    assign RETRY_COUNT = retry_reg;
    assign STATE       = state_reg;

endmodule
